// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch definitions: funct3 condition codes and the reserved-encoding check.
package branch_resolve_unit_pkg;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  // funct3[2:1] == 01 (010/011) has no branch meaning.
  localparam logic [1:0] FUNCT3_RSVD_HI = 2'b01;

  function automatic logic funct3_is_illegal(input logic [2:0] funct3);
    return funct3[2:1] == FUNCT3_RSVD_HI;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluation for the branch resolve unit.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = funct3_is_illegal(funct3);
    case (funct3)
      FUNCT3_BEQ:  taken = (rs1 == rs2);
      FUNCT3_BNE:  taken = (rs1 != rs2);
      FUNCT3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      FUNCT3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      FUNCT3_BLTU: taken = (rs1 <  rs2);
      FUNCT3_BGEU: taken = (rs1 >= rs2);
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution: condition, target, prediction check, one registered record.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_mispredict,
  output logic            out_misalign,
  output logic            out_illegal
`ifdef BRU_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_mispred
`endif
);

  localparam logic CHECK_BIT1 = (IALIGN == 32);

  logic            cond_taken;
  logic            cond_illegal;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthrough;
  logic            misalign_next;
  logic            mispredict_next;
  logic [XLEN-1:0] next_pc_next;
  logic            accept;

  logic            out_valid_reg;
  logic            taken_reg;
  logic [XLEN-1:0] next_pc_reg;
  logic            mispredict_reg;
  logic            misalign_reg;
  logic            illegal_reg;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  always_comb begin
    target          = in_pc + in_imm;
    fallthrough     = in_pc + XLEN'(4);
    misalign_next   = cond_taken & (target[0] | (CHECK_BIT1 & target[1]));
    next_pc_next    = cond_taken ? target : fallthrough;
    // Misaligned targets go to the trap path, so they never request a redirect.
    mispredict_next = !cond_illegal && !misalign_next &&
                      ((in_pred_taken != cond_taken) ||
                       (cond_taken && in_pred_taken && (in_pred_target != target)));
  end

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      taken_reg      <= 1'b0;
      next_pc_reg    <= '0;
      mispredict_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (in_ready) begin
        out_valid_reg <= in_valid;
      end
      if (accept) begin
        taken_reg      <= cond_taken;
        next_pc_reg    <= next_pc_next;
        mispredict_reg <= mispredict_next;
        misalign_reg   <= misalign_next;
        illegal_reg    <= cond_illegal;
      end
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_taken      = taken_reg;
  assign out_next_pc    = next_pc_reg;
  assign out_mispredict = mispredict_reg;
  assign out_misalign   = misalign_reg;
  assign out_illegal    = illegal_reg;

`ifdef BRU_STATS_EN
  logic       stat_fire;
  logic [2:0] stat_inc;

  assign stat_fire = out_valid_reg && out_ready && !flush && !illegal_reg;
  assign stat_inc  = {stat_fire && mispredict_reg, stat_fire && taken_reg, stat_fire};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (stat_clr) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stat_branches = g_stat[0].cnt_reg;
  assign stat_taken    = g_stat[1].cnt_reg;
  assign stat_mispred  = g_stat[2].cnt_reg;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (IALIGN=32 and IALIGN=16 instances).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_16;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0, in_pred_target = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_pred_taken = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_taken, out_mispredict, out_misalign, out_illegal;
  logic [31:0] out_next_pc;
  logic        o16_valid, o16_taken, o16_mispredict, o16_misalign, o16_illegal;
  logic [31:0] o16_next_pc;
`ifdef BRU_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_branches, stat_taken, stat_mispred;
  logic [3:0]  s16_branches, s16_taken, s16_mispred;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .IALIGN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .out_misalign(out_misalign), .out_illegal(out_illegal)
`ifdef BRU_STATS_EN
    , .stat_clr(stat_clr), .stat_branches(stat_branches), .stat_taken(stat_taken),
    .stat_mispred(stat_mispred)
`endif
  );

  branch_resolve_unit #(.XLEN(32), .IALIGN(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_16),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(o16_valid), .out_ready(out_ready), .out_taken(o16_taken),
    .out_next_pc(o16_next_pc), .out_mispredict(o16_mispredict),
    .out_misalign(o16_misalign), .out_illegal(o16_illegal)
`ifdef BRU_STATS_EN
    , .stat_clr(stat_clr), .stat_branches(s16_branches), .stat_taken(s16_taken),
    .stat_mispred(s16_mispred)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Present one request; returns #1 after the edge that accepts it.
  task automatic drive(input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt);
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_pc = pc; in_imm = imm;
    in_pred_taken = pt; in_pred_target = ptgt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_rec(input string tag, input logic tk, input logic [31:0] npc,
                           input logic mp, input logic ma, input logic il);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".taken"}, 64'(out_taken), 64'(tk));
    check({tag, ".next_pc"}, 64'(out_next_pc), 64'(npc));
    check({tag, ".mispredict"}, 64'(out_mispredict), 64'(mp));
    check({tag, ".misalign"}, 64'(out_misalign), 64'(ma));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(il));
  endtask

  initial begin
    #2;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.next_pc", 64'(out_next_pc), 64'd0);
    check("reset.taken", 64'(out_taken), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    drive(32'd5, 32'd5, 3'b000, 32'h100, 32'h20, 1'b1, 32'h120);
    check_rec("beq_taken", 1'b1, 32'h120, 1'b0, 1'b0, 1'b0);
    drive(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h200, 32'h40, 1'b1, 32'h240);
    check_rec("blt_signed", 1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
    drive(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h200, 32'h40, 1'b1, 32'h240);
    check_rec("bltu_not_taken", 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
    drive(32'd1, 32'd2, 3'b001, 32'h300, 32'h10, 1'b1, 32'h400);
    check_rec("bne_wrong_tgt", 1'b1, 32'h310, 1'b1, 1'b0, 1'b0);
    drive(32'd3, 32'd3, 3'b001, 32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0);
    check_rec("fallthrough_wrap", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(32'd5, 32'd3, 3'b111, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h0);
    check_rec("target_wrap", 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    drive(32'h8000_0000, 32'd1, 3'b101, 32'h700, 32'h8, 1'b0, 32'h0);
    check_rec("bge_neg", 1'b0, 32'h704, 1'b0, 1'b0, 1'b0);
    drive(32'd1, 32'd1, 3'b000, 32'h100, 32'h2, 1'b1, 32'h102);
    check_rec("misalign32", 1'b1, 32'h102, 1'b0, 1'b1, 1'b0);
    check("misalign16.misalign", 64'(o16_misalign), 64'd0);
    check("misalign16.next_pc", 64'(o16_next_pc), 64'h102);
    check("misalign16.mispredict", 64'(o16_mispredict), 64'd0);
    drive(32'd1, 32'd1, 3'b000, 32'h100, 32'h3, 1'b0, 32'h0);
    check("odd16.misalign", 64'(o16_misalign), 64'd1);
    check("odd16.mispredict", 64'(o16_mispredict), 64'd0);
    drive(32'd9, 32'd9, 3'b010, 32'h800, 32'h20, 1'b1, 32'h820);
    check_rec("illegal_010", 1'b0, 32'h804, 1'b0, 1'b0, 1'b1);

    // Back-pressure: A held for 3 cycles while B waits.
    idle_cycle();
    check("drain.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(32'd0, 32'd0, 3'b000, 32'h1000, 32'h40, 1'b1, 32'h1040);
    in_rs1 = 32'd1; in_rs2 = 32'd0; in_funct3 = 3'b000; in_pc = 32'h2000;
    in_imm = 32'h40; in_pred_taken = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold.in_ready", 64'(in_ready), 64'd0);
      check("hold.valid", 64'(out_valid), 64'd1);
      check("hold.next_pc", 64'(out_next_pc), 64'h1040);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release.B_next_pc", 64'(out_next_pc), 64'h2004);
    check("release.B_valid", 64'(out_valid), 64'd1);
    idle_cycle();
    check("release.no_dup", 64'(out_valid), 64'd0);

    // Full rate: one record per cycle.
    for (int i = 0; i < 3; i++) begin
      drive(32'd7, 32'd7, 3'b000, 32'h3000 + 32'(i * 16), 32'h100, 1'b1, 32'h3100 + 32'(i * 16));
      check("fullrate.next_pc", 64'(out_next_pc), 64'(32'h3100 + 32'(i * 16)));
      check("fullrate.valid", 64'(out_valid), 64'd1);
    end
    idle_cycle();

    // Flush while stalled kills held record and the same-cycle input.
    out_ready = 1'b0;
    drive(32'd0, 32'd0, 3'b011, 32'h500, 32'h8, 1'b1, 32'h508);
    check_rec("illegal_011", 1'b0, 32'h504, 1'b0, 1'b0, 1'b1);
    in_funct3 = 3'b000; in_pc = 32'h600; in_valid = 1'b1; flush = 1'b1; #1;
    check("flush.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush_idle.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_drop.valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    // Asynchronous reset mid-record.
    drive(32'd4, 32'd4, 3'b000, 32'h900, 32'h10, 1'b1, 32'h910);
    check("pre_rst.valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0; #1;
    check("async_rst.valid", 64'(out_valid), 64'd0);
    check("async_rst.next_pc", 64'(out_next_pc), 64'd0);
    check("async_rst.taken", 64'(out_taken), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef BRU_STATS_EN
    check("stat_rst.branches", 64'(stat_branches), 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(32'd1, 32'd1, (i < 4) ? 3'b000 : 3'b001, 32'h1000 + 32'(i * 16), 32'h40,
            (i < 2) ? 1'b0 : (i < 4), 32'h1040 + 32'(i * 16));
    end
    drive(32'd1, 32'd1, 3'b010, 32'h4000, 32'h40, 1'b1, 32'h4040);
    idle_cycle();
    check("stat.branches", 64'(stat_branches), 64'd10);
    check("stat.taken", 64'(stat_taken), 64'd4);
    check("stat.mispred", 64'(stat_mispred), 64'd2);
    drive(32'd1, 32'd1, 3'b000, 32'h100, 32'h20, 1'b0, 32'h0);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr.branches", 64'(stat_branches), 64'd0);
    check("stat_clr.mispred", 64'(stat_mispred), 64'd0);
    for (int i = 0; i < 20; i++) begin
      drive(32'd1, 32'd2, 3'b001, 32'h100, 32'h20, 1'b1, 32'h120);
    end
    idle_cycle();
    check("stat20.branches", 64'(stat_branches), 64'd20);
    check("stat_sat4.branches", 64'(s16_branches), 64'd15);
    check("stat_sat4.taken", 64'(s16_taken), 64'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
